// File: rtl/mul_pkg.sv
// mul_pkg: shared state encoding and sizing for the shift-and-add multiplier.
package mul_pkg;
    localparam int MUL_WIDTH = 8;
    localparam int MUL_STEP_W = 4;
    localparam int MUL_LATENCY = MUL_WIDTH + 1;
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } mul_state_t;
endpackage

// File: rtl/mul_ctrl.sv
// mul_ctrl: sequencing FSM and step counter for the shift-and-add multiplier.
module mul_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH  = MUL_WIDTH,
    parameter int STEP_W = MUL_STEP_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic load,
    output logic step,
    output logic last,
    output logic busy,
    output logic done
);
    mul_state_t state;
    logic [STEP_W-1:0] count;
    assign load = (state == S_IDLE) && start;
    assign step = (state == S_RUN);
    assign last = step && (count == STEP_W'(WIDTH - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state <= S_RUN;
                    count <= '0;
                    busy  <= 1'b1;
                end
                S_RUN: begin
                    count <= count + 1'b1;
                    if (last) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    count <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: 8x8 unsigned sequential multiplier reusing the external adder.
// Define MUL_OVF_FLAG_EN to add the Ovf output (product exceeds WIDTH bits).
module shift_add_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH  = MUL_WIDTH,
    parameter int STEP_W = MUL_STEP_W
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Start,
    input  logic [WIDTH-1:0]   Multiplicand,
    input  logic [WIDTH-1:0]   Multiplier,
    output logic               Busy,
    output logic               Done,
`ifdef MUL_OVF_FLAG_EN
    output logic               Ovf,
`endif
    output logic [2*WIDTH-1:0] Product,
    output logic [WIDTH-1:0]   Adder_A,
    output logic [WIDTH-1:0]   Adder_B,
    output logic               Adder_Carry_in,
    input  logic [WIDTH-1:0]   Adder_Sum,
    input  logic               Adder_Carry_out
);
    logic [WIDTH-1:0] acc, mq, mreg;
    logic [2*WIDTH-1:0] shifted;
    logic load, step, last;
    mul_ctrl #(.WIDTH(WIDTH), .STEP_W(STEP_W)) u_ctrl (
        .clk(Clk), .rst_n(Reset_n), .start(Start),
        .load(load), .step(step), .last(last), .busy(Busy), .done(Done)
    );
    assign Adder_A = acc;
    assign Adder_B = (step && mq[0]) ? mreg : '0;
    assign Adder_Carry_in = 1'b0;
    // Carry lands in the accumulator MSB; the multiplier bit just consumed drops off the bottom.
    assign shifted = {Adder_Carry_out, Adder_Sum, mq[WIDTH-1:1]};
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            acc     <= '0;
            mq      <= '0;
            mreg    <= '0;
            Product <= '0;
`ifdef MUL_OVF_FLAG_EN
            Ovf     <= 1'b0;
`endif
        end else if (load) begin
            acc  <= '0;
            mq   <= Multiplier;
            mreg <= Multiplicand;
        end else if (step) begin
            {acc, mq} <= shifted;
            if (last) begin
                Product <= shifted;
`ifdef MUL_OVF_FLAG_EN
                Ovf     <= |shifted[2*WIDTH-1:WIDTH];
`endif
            end
        end
    end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed vectors plus hand sequences for the shift-and-add multiplier.
module tb_shift_add_multiplier;
    import mul_pkg::*;
    logic Clk = 1'b0, Reset_n = 1'b0, Start = 1'b0;
    logic [7:0] Multiplicand = '0, Multiplier = '0;
    logic Busy, Done, Adder_Carry_in, Adder_Carry_out;
    logic [15:0] Product;
    logic [7:0] Adder_A, Adder_B, Adder_Sum;
`ifdef MUL_OVF_FLAG_EN
    logic Ovf;
`endif
    shift_add_multiplier dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start),
        .Multiplicand(Multiplicand), .Multiplier(Multiplier),
        .Busy(Busy), .Done(Done),
`ifdef MUL_OVF_FLAG_EN
        .Ovf(Ovf),
`endif
        .Product(Product), .Adder_A(Adder_A), .Adder_B(Adder_B),
        .Adder_Carry_in(Adder_Carry_in), .Adder_Sum(Adder_Sum),
        .Adder_Carry_out(Adder_Carry_out)
    );
    // Stand-in for the CPU's combinational 8-bit adder.
    assign {Adder_Carry_out, Adder_Sum} = {1'b0, Adder_A} + {1'b0, Adder_B} + {8'd0, Adder_Carry_in};
    always #5 Clk = ~Clk;
    int checks = 0, failures = 0, cyc = 0;
    always @(posedge Clk) cyc++;
    logic carry_seen, b_nonzero;
    typedef struct {
        logic [7:0]  m;
        logic [7:0]  q;
        logic [15:0] p;
    } vec_t;
    vec_t vecs[6];
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask
    task automatic check_result(input string name, input logic [15:0] exp);
        check({name, " product"}, Product, exp);
`ifdef MUL_OVF_FLAG_EN
        check({name, " ovf"}, Ovf, |exp[15:8]);
`endif
    endtask
    task automatic run_op(input logic [7:0] m, input logic [7:0] q, input logic [15:0] exp, input string name);
        int k;
        @(negedge Clk);
        Multiplicand = m; Multiplier = q; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0; Multiplicand = ~m; Multiplier = ~q;
        check({name, " busy"}, Busy, 1);
        carry_seen = 1'b0; b_nonzero = 1'b0; k = 0;
        while (!Done && k < 20) begin
            carry_seen |= Adder_Carry_out;
            b_nonzero |= (Adder_B != 0);
            @(negedge Clk);
            k++;
        end
        check({name, " latency"}, k, MUL_LATENCY - 1);
        check_result(name, exp);
        @(negedge Clk);
        check({name, " done_drop"}, Done, 0);
        check({name, " busy_drop"}, Busy, 0);
    endtask
    initial begin
        int k, extra, busy_low, lastd;
        logic [7:0] hm[3], hq[3];
        logic [15:0] hp[3];
        vecs[0] = '{8'h0D, 8'h0B, 16'h008F};
        vecs[1] = '{8'h01, 8'hFF, 16'h00FF};
        vecs[2] = '{8'h80, 8'h80, 16'h4000};
        vecs[3] = '{8'hC3, 8'h5A, 16'h448E};
        vecs[4] = '{8'h10, 8'h0F, 16'h00F0};
        vecs[5] = '{8'hFF, 8'h01, 16'h00FF};
        hm[0] = 8'h03; hq[0] = 8'h05; hp[0] = 16'h000F;
        hm[1] = 8'h07; hq[1] = 8'h09; hp[1] = 16'h003F;
        hm[2] = 8'h80; hq[2] = 8'h02; hp[2] = 16'h0100;
        #1;
        check("reset busy", Busy, 0);
        check("reset done", Done, 0);
        check("reset product", Product, 0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        for (int i = 0; i < 6; i++) run_op(vecs[i].m, vecs[i].q, vecs[i].p, $sformatf("vec%0d", i));
        run_op(8'hFF, 8'hFF, 16'hFE01, "ffxff");
        check("ffxff carry_seen", carry_seen, 1);
        run_op(8'hA5, 8'h00, 16'h0000, "a5x00");
        check("a5x00 adder_b_zero", b_nonzero, 0);
        // Second Start during RUN must be dropped without a second completion.
        @(negedge Clk);
        Multiplicand = 8'h0D; Multiplier = 8'h0B; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0; k = 0; busy_low = 0;
        while (!Done && k < 20) begin
            if (k == 3) begin Start = 1'b1; Multiplicand = 8'h02; Multiplier = 8'h03; end
            if (k == 4) Start = 1'b0;
            busy_low += (Busy == 1'b0) ? 1 : 0;
            @(negedge Clk);
            k++;
        end
        check("ignore latency", k, 8);
        check("ignore busy_held", busy_low, 0);
        check_result("ignore", 16'h008F);
        extra = 0;
        repeat (12) begin @(negedge Clk); extra += Done ? 1 : 0; end
        check("ignore extra_done", extra, 0);
        check("ignore product_held", Product, 16'h008F);
        // Asynchronous reset in the middle of RUN.
        @(negedge Clk);
        Multiplicand = 8'hFF; Multiplier = 8'hFF; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (4) @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        check("midreset busy", Busy, 0);
        check("midreset done", Done, 0);
        check("midreset product", Product, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        run_op(8'h10, 8'h10, 16'h0100, "after_reset");
        // Start held high: back-to-back operations with one idle cycle between.
        @(negedge Clk);
        Multiplicand = hm[0]; Multiplier = hq[0]; Start = 1'b1;
        lastd = 0;
        for (int i = 0; i < 3; i++) begin
            k = 0;
            while (!Done && k < 30) begin @(negedge Clk); k++; end
            check($sformatf("held%0d timeout", i), (k < 30) ? 1 : 0, 1);
            check_result($sformatf("held%0d", i), hp[i]);
            if (i > 0) check($sformatf("held%0d spacing", i), cyc - lastd, 10);
            lastd = cyc;
            if (i < 2) begin Multiplicand = hm[i+1]; Multiplier = hq[i+1]; end
            @(negedge Clk);
        end
        Start = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
